axis_pkt_master: RTL and testbench



---
 rtl/axis_pkt_master.sv | 154 +++++++++++++++
 tb/tb_axis_pkt_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_master.sv
// AXI-Stream packetiser: FWFT data FIFO plus length-command FIFO feeding a
// back-to-back packet emitter. Optional PKT_STATS_EN adds pkt/beat counters.
module axis_pkt_master #(
    parameter int WIDTH     = 32,
    parameter int MAX_LEN   = 256,
    parameter int DEPTH     = 8,
    parameter int CFG_DEPTH = 4,
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    input  logic             config_valid,
    input  logic [LW-1:0]    config_len,
    output logic             config_ready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic             len_err
`ifdef PKT_STATS_EN
    ,
    output logic [15:0]      pkt_cnt,
    output logic [31:0]      beat_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CFG_DEPTH);
    localparam logic [AW:0] D_FULL = (AW+1)'(DEPTH);
    localparam logic [CW:0] C_FULL = (CW+1)'(CFG_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    // data FIFO
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      d_occ, d_occ_nxt;
    logic             push, pop;

    // config FIFO
    logic [LW-1:0]    cmem [CFG_DEPTH];
    logic [CW-1:0]    c_wr, c_rd;
    logic [CW:0]      c_occ, c_occ_nxt;
    logic             cfg_legal, cfg_push, cfg_pop;

    logic [LW-1:0]    count, len_r;
    logic             beat;

    assign push      = valid_in && ready;
    assign beat      = m_axis_tvalid && m_axis_tready;
    assign pop       = beat;
    assign cfg_legal = (config_len != '0) && (config_len <= LW'(MAX_LEN));
    assign cfg_push  = config_valid && config_ready && cfg_legal;

    assign m_axis_tvalid = (state == RUN) && (d_occ != '0);
    assign m_axis_tdata  = mem[rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && (count == len_r);
    assign busy          = (state == RUN);

    always_comb begin
        d_occ_nxt = d_occ;
        case ({push, pop})
            2'b10:   d_occ_nxt = d_occ + (AW+1)'(1);
            2'b01:   d_occ_nxt = d_occ - (AW+1)'(1);
            default: d_occ_nxt = d_occ;
        endcase
        c_occ_nxt = c_occ;
        case ({cfg_push, cfg_pop})
            2'b10:   c_occ_nxt = c_occ + (CW+1)'(1);
            2'b01:   c_occ_nxt = c_occ - (CW+1)'(1);
            default: c_occ_nxt = c_occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
        if (cfg_push) cmem[c_wr] <= config_len;
    end

    // ready flags are registered from next occupancy, so a pop never admits a same-cycle push
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            d_occ        <= '0;
            ready        <= 1'b1;
            c_wr         <= '0;
            c_rd         <= '0;
            c_occ        <= '0;
            config_ready <= 1'b1;
            len_err      <= 1'b0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            if (cfg_push) c_wr   <= c_wr + CW'(1);
            if (cfg_pop)  c_rd   <= c_rd + CW'(1);
            d_occ        <= d_occ_nxt;
            c_occ        <= c_occ_nxt;
            ready        <= (d_occ_nxt != D_FULL);
            config_ready <= (c_occ_nxt != C_FULL);
            if (config_valid && !cfg_legal) len_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_pop   = 1'b0;
        case (state)
            IDLE: if (c_occ != '0) begin
                cfg_pop   = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (beat && m_axis_tlast) begin
                if (c_occ != '0) cfg_pop   = 1'b1;
                else             state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= LW'(1);
            len_r <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_pop) begin
                len_r <= cmem[c_rd];
                count <= LW'(1);
            end else if (beat && m_axis_tlast) begin
                count <= LW'(1);
            end else if (beat) begin
                count <= count + LW'(1);
            end
        end
    end

`ifdef PKT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            if (beat && m_axis_tlast) pkt_cnt <= pkt_cnt + 16'd1;
            if (beat)                 beat_cnt <= beat_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axis_pkt_master.sv
// Bench for axis_pkt_master: scenario tasks plus a queue-based scoreboard of
// the expected beat stream (data order and packet boundaries).
module tb_axis_pkt_master;
    localparam int WIDTH = 32, MAX_LEN = 256, DEPTH = 8, CFG_DEPTH = 4;
    localparam int LW = $clog2(MAX_LEN + 1);

    logic             clk = 0, rst = 1;
    logic             valid_in = 0, config_valid = 0, m_axis_tready = 0;
    logic [WIDTH-1:0] data_in = '0;
    logic [LW-1:0]    config_len = '0;
    logic             ready, config_ready, m_axis_tvalid, m_axis_tlast, busy, len_err;
    logic [WIDTH-1:0] m_axis_tdata;
`ifdef PKT_STATS_EN
    logic [15:0]      pkt_cnt;
    logic [31:0]      beat_cnt;
`endif

    axis_pkt_master #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .DEPTH(DEPTH), .CFG_DEPTH(CFG_DEPTH)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .ready(ready),
        .config_valid(config_valid), .config_len(config_len), .config_ready(config_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .len_err(len_err)
`ifdef PKT_STATS_EN
        , .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // reference model: accepted words in order, accepted lengths in order
    logic [WIDTH-1:0] data_q[$];
    int               len_q[$];
    int               rem = 0;
    bit               mon_en = 0, prev_hold = 0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;

    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_d;
        logic             exp_l;
        if (rst) begin
            data_q.delete(); len_q.delete(); rem = 0; prev_hold = 0; mon_en = 1;
        end else if (mon_en) begin
            n_cmp++;
            if (ready !== (data_q.size() < DEPTH)) begin
                n_err++; $display("FAIL ready_occ: got %b want %b (occ %0d)", ready, data_q.size() < DEPTH, data_q.size());
            end
            n_cmp++;
            if (m_axis_tlast && !m_axis_tvalid) begin
                n_err++; $display("FAIL tlast_no_valid: tlast=1 while tvalid=0");
            end
            if (prev_hold) begin
                n_cmp++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                    n_err++; $display("FAIL hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                                      m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (rem == 0) begin
                    if (len_q.size() == 0) begin
                        n_cmp++; n_err++; $display("FAIL beat_no_cmd: got beat %h, want no beat", m_axis_tdata);
                    end else rem = len_q.pop_front();
                end
                n_cmp++;
                if (data_q.size() == 0) begin
                    n_err++; $display("FAIL beat_no_data: got beat %h, want no beat", m_axis_tdata);
                end else begin
                    exp_d = data_q.pop_front();
                    exp_l = (rem == 1);
                    if (m_axis_tdata !== exp_d || m_axis_tlast !== exp_l) begin
                        n_err++; $display("FAIL beat: got d=%h l=%b want d=%h l=%b", m_axis_tdata, m_axis_tlast, exp_d, exp_l);
                    end
                end
                if (rem > 0) rem--;
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
            if (valid_in && ready) data_q.push_back(data_in);
            if (config_valid && config_ready && config_len >= 1 && config_len <= MAX_LEN)
                len_q.push_back(int'(config_len));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        valid_in = 0; config_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_in(); m_axis_tready = 1;
        tick(); tick();
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1)         begin n_err++; $display("FAIL rst_ready: got %b want 1", ready); end
        n_cmp++; if (config_ready !== 1'b1)  begin n_err++; $display("FAIL rst_cfg_ready: got %b want 1", config_ready); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tlast !== 1'b0)  begin n_err++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
        n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (len_err !== 1'b0)       begin n_err++; $display("FAIL rst_len_err: got %b want 0", len_err); end
        tick(); rst = 0;
    endtask

    task automatic test_single();
        int nb = 0, first = -1, lastc = -1, nlast = 0;
        bit busy_h[40];
        for (int i = 0; i < 40; i++) begin
            valid_in = (i < 4); data_in = WIDTH'(32'hA0 + i);
            config_valid = (i == 0); config_len = LW'(4); m_axis_tready = 1;
            @(negedge clk);
            busy_h[i] = busy;
            if (m_axis_tvalid && m_axis_tready) begin
                if (first < 0) first = i;
                nb++;
                if (m_axis_tlast) begin nlast++; lastc = i; end
            end
            tick();
        end
        idle_in();
        n_cmp++; if (nb != 4)    begin n_err++; $display("FAIL single_beats: got %0d want 4", nb); end
        n_cmp++; if (nlast != 1) begin n_err++; $display("FAIL single_tlasts: got %0d want 1", nlast); end
        n_cmp++; if (lastc - first != 3) begin n_err++; $display("FAIL single_span: got %0d want 3", lastc - first); end
        n_cmp++; if (first != 2) begin n_err++; $display("FAIL single_latency: got first beat cycle %0d want 2", first); end
        if (lastc >= 0 && lastc < 39) begin
            n_cmp++;
            if (busy_h[lastc] !== 1'b1 || busy_h[lastc+1] !== 1'b0) begin
                n_err++; $display("FAIL single_busy_fall: got %b%b want 10", busy_h[lastc], busy_h[lastc+1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nb = 0, first = -1, lastc = -1, nlast = 0, gaps = 0, idle_run = 0;
        int lb[2] = '{0, 0};
        bit v_h[40], b_h[40];
        for (int i = 0; i < 40; i++) begin
            valid_in = (i < 5); data_in = $urandom;
            config_valid = (i < 2); config_len = (i == 0) ? LW'(2) : LW'(3); m_axis_tready = 1;
            @(negedge clk);
            v_h[i] = m_axis_tvalid; b_h[i] = busy;
            if (m_axis_tvalid && m_axis_tready) begin
                if (first < 0) first = i;
                nb++;
                if (m_axis_tlast) begin
                    if (nlast < 2) lb[nlast] = nb;
                    nlast++; lastc = i;
                end
            end
            tick();
        end
        idle_in();
        for (int i = 0; i < 40; i++)
            if (first >= 0 && i >= first && i <= lastc) begin
                if (!v_h[i]) gaps++;
                if (!b_h[i]) idle_run++;
            end
        n_cmp++; if (nb != 5)    begin n_err++; $display("FAIL b2b_beats: got %0d want 5", nb); end
        n_cmp++; if (nlast != 2 || lb[0] != 2 || lb[1] != 5) begin
            n_err++; $display("FAIL b2b_tlast_pos: got %0d lasts at %0d,%0d want 2 at 2,5", nlast, lb[0], lb[1]);
        end
        n_cmp++; if (gaps != 0)     begin n_err++; $display("FAIL b2b_bubble: got %0d idle cycles want 0", gaps); end
        n_cmp++; if (idle_run != 0) begin n_err++; $display("FAIL b2b_busy: got %0d non-busy cycles want 0", idle_run); end
    endtask

    task automatic test_backpressure();
        bit pat[5] = '{1, 0, 0, 1, 1};
        logic [WIDTH-1:0] td[5];
        bit tl[5], tv[5], xf[5];
        int nx = 0;
        bit seen = 0;
        m_axis_tready = 0;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1; data_in = $urandom;
            config_valid = (i == 0); config_len = LW'(3);
            @(negedge clk); tick();
        end
        idle_in();
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) seen = 1;
            tick();
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL bp_timeout: got no tvalid want tvalid within 10 cycles"); end
        for (int k = 0; k < 5; k++) begin
            m_axis_tready = pat[k];
            @(negedge clk);
            td[k] = m_axis_tdata; tl[k] = m_axis_tlast; tv[k] = m_axis_tvalid;
            xf[k] = m_axis_tvalid && m_axis_tready;
            if (xf[k]) nx++;
            tick();
        end
        m_axis_tready = 1;
        n_cmp++; if (nx != 3) begin n_err++; $display("FAIL bp_xfers: got %0d want 3", nx); end
        n_cmp++; if (!(tv[1] && tv[2] && td[1] === td[2] && tl[1] === tl[2])) begin
            n_err++; $display("FAIL bp_stable: got v=%b%b d=%h/%h want held", tv[1], tv[2], td[1], td[2]);
        end
        n_cmp++; if (!(xf[4] && tl[4] && !tl[3] && !tl[0])) begin
            n_err++; $display("FAIL bp_tlast: got xf4=%b tl=%b%b%b want tlast only on third", xf[4], tl[0], tl[3], tl[4]);
        end
        repeat (3) begin @(negedge clk); tick(); end
    endtask

    task automatic test_full();
        bit r_h[9];
        int nb = 0, nlast = 0, lastn = 0;
        m_axis_tready = 0;
        for (int i = 0; i < 9; i++) begin
            valid_in = 1; data_in = $urandom;
            @(negedge clk); r_h[i] = ready; tick();
        end
        idle_in();
        n_cmp++; if (r_h[7] !== 1'b1 || r_h[8] !== 1'b0) begin
            n_err++; $display("FAIL full_ready: got %b%b want 10", r_h[7], r_h[8]);
        end
        m_axis_tready = 1;
        for (int i = 0; i < 20; i++) begin
            config_valid = (i == 0); config_len = LW'(8);
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                nb++;
                if (m_axis_tlast) begin nlast++; lastn = nb; end
            end
            tick();
        end
        idle_in();
        n_cmp++; if (nb != 8) begin n_err++; $display("FAIL full_drain: got %0d want 8", nb); end
        n_cmp++; if (nlast != 1 || lastn != 8) begin n_err++; $display("FAIL full_tlast: got %0d at %0d want 1 at 8", nlast, lastn); end
    endtask

    task automatic test_illegal();
        bit any_v = 0, any_b = 0;
        for (int i = 0; i < 12; i++) begin
            config_valid = (i < 2); config_len = (i == 0) ? LW'(0) : LW'(MAX_LEN + 1);
            valid_in = (i < 2); data_in = $urandom; m_axis_tready = 1;
            @(negedge clk);
            if (m_axis_tvalid) any_v = 1;
            if (busy) any_b = 1;
            tick();
        end
        idle_in();
        @(negedge clk);
        n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL illegal_len_err: got %b want 1", len_err); end
        n_cmp++; if (any_v || any_b)   begin n_err++; $display("FAIL illegal_queued: got tvalid=%b busy=%b want 0 0", any_v, any_b); end
        n_cmp++; if (config_ready !== 1'b1) begin n_err++; $display("FAIL illegal_cfg_ready: got %b want 1", config_ready); end
        tick();
    endtask

    task automatic test_reset_mid();
        int nb = 0, nlast = 0;
        rst = 1; tick(); rst = 0;
        m_axis_tready = 1;
        for (int i = 0; i < 20 && nb < 2; i++) begin
            valid_in = (i < 6); data_in = $urandom;
            config_valid = (i == 0); config_len = LW'(6);
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                nb++;
                if (m_axis_tlast) nlast++;
            end
            if (nb < 2) tick();
        end
        n_cmp++; if (nb != 2 || nlast != 0) begin n_err++; $display("FAIL mid_pre: got %0d beats %0d lasts want 2 0", nb, nlast); end
        tick();
        rst = 1; idle_in();
        tick();
        rst = 0;
        @(negedge clk);
        n_cmp++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            n_err++; $display("FAIL mid_tvalid: got v=%b l=%b want 0 0", m_axis_tvalid, m_axis_tlast);
        end
        n_cmp++; if (ready !== 1'b1 || config_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_ready: got %b%b want 11", ready, config_ready);
        end
        n_cmp++; if (busy !== 1'b0 || len_err !== 1'b0) begin
            n_err++; $display("FAIL mid_busy: got busy=%b len_err=%b want 0 0", busy, len_err);
        end
        tick();
        nb = 0; nlast = 0;
        for (int i = 0; i < 10; i++) begin
            valid_in = (i == 0); data_in = $urandom;
            config_valid = (i == 0); config_len = LW'(1);
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                nb++;
                if (m_axis_tlast) nlast++;
            end
            tick();
        end
        idle_in();
        n_cmp++; if (nb != 1 || nlast != 1) begin n_err++; $display("FAIL mid_after: got %0d beats %0d lasts want 1 1", nb, nlast); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
